// File: rtl/pred_pack_writer.sv
// pred_pack_writer: packs 8-bit class predictions eight to a 64-bit word,
// buffers the words in a first-word-fall-through FIFO and streams them to
// the DMA write channel, then pulses done once per burst.
// Optional feature macro: PRED_PACK_DEBUG_EN (exposes words_out, FIFO
// flags and FSM state on debug; otherwise debug is tied to zero).
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both high; a producer holding valid high keeps
// its data stable until that transfer, and ready never depends on valid.
module pred_pack_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int PRED_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       burst_len,
  input  logic              pred_valid,
  output logic              pred_ready,
  input  logic [PRED_W-1:0] pred_data,
  output logic              dma_write_chnl_valid,
  input  logic              dma_write_chnl_ready,
  output logic [63:0]       dma_write_chnl_data,
  output logic              done,
  output logic [31:0]       debug
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   len_q;
  logic [31:0]   cnt;
  logic [2:0]    lane;
  logic [63:0]   pack_q;
  logic [63:0]   merged;
  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pred_fire;
  logic          last_pred;
  logic          push;
  logic          pop;
  logic          done_q;

  assign lane       = cnt[2:0];
  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign pred_ready = (state == PACK) && !fifo_full;
  assign pred_fire  = pred_valid && pred_ready;
  assign last_pred  = (cnt == len_q - 32'd1);
  // A word leaves the packer when its top lane fills or the burst ends.
  assign push       = pred_fire && ((lane == 3'd7) || last_pred);
  assign pop        = !fifo_empty && dma_write_chnl_ready;
  // Upper lanes of pack_q are always zero, so OR-ing in the new byte is exact.
  assign merged     = pack_q | (64'(pred_data) << {lane, 3'b000});

  assign dma_write_chnl_valid = !fifo_empty;
  assign dma_write_chnl_data  = mem[rd_ptr];
  assign done                 = done_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = (burst_len == 32'd0) ? DONE : PACK;
      PACK:  if (pred_fire && last_pred) state_next = DRAIN;
      DRAIN: if (fifo_empty) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done is high during the single cycle the FSM sits in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= (state_next == DONE);
  end

  // Burst length latch, prediction counter and word assembly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q  <= 32'd0;
      cnt    <= 32'd0;
      pack_q <= 64'd0;
    end else if ((state == IDLE) && start) begin
      len_q  <= burst_len;
      cnt    <= 32'd0;
      pack_q <= 64'd0;
    end else if (pred_fire) begin
      cnt    <= cnt + 32'd1;
      pack_q <= push ? 64'd0 : merged;
    end
  end

  // FIFO storage; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= merged;
  end

  // FIFO pointers and occupancy; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

`ifdef PRED_PACK_DEBUG_EN
  logic [15:0] words_out;
  logic [31:0] debug_q;

  // Output handshakes since the last accepted start, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n)                       words_out <= 16'd0;
    else if ((state == IDLE) && start) words_out <= 16'd0;
    else if (pop && (words_out != 16'hFFFF)) words_out <= words_out + 16'd1;
  end

  // Registered so the whole word reads zero while reset is held.
  always_ff @(posedge clk) begin
    if (!rst_n) debug_q <= 32'd0;
    else        debug_q <= {words_out, 11'd0, fifo_full, fifo_empty, 1'b0, state};
  end

  assign debug = debug_q;
`else
  assign debug = 32'd0;
`endif

endmodule

// File: tb/tb_pred_pack_writer.sv
// Bench for pred_pack_writer: table of directed bursts, a FIFO back-pressure
// sequence, a reset-mid-burst sequence and a long randomly throttled burst,
// all scored against words built from the prediction list.
module tb_pred_pack_writer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] burst_len = 32'd0;
  logic        pred_valid = 1'b0;
  logic        pred_ready;
  logic [7:0]  pred_data = 8'd0;
  logic        dma_valid;
  logic        dma_ready = 1'b0;
  logic [63:0] dma_data;
  logic        done;
  logic [31:0] debug;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int words_seen = 0;
  int done_cnt = 0;
  int last_hs_cyc = 0;
  int done_cyc = 0;

  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic [7:0]  pred_q[$];

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [63:0] prev_data = 64'd0;

  typedef struct {
    int          len;
    logic [7:0]  base;
    int          nwords;
    logic [63:0] first;
    logic [63:0] last;
  } vec_t;

  vec_t vecs[5];

  pred_pack_writer #(.FIFO_DEPTH(DEPTH), .PRED_W(8)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .burst_len            (burst_len),
    .pred_valid           (pred_valid),
    .pred_ready           (pred_ready),
    .pred_data            (pred_data),
    .dma_write_chnl_valid (dma_valid),
    .dma_write_chnl_ready (dma_ready),
    .dma_write_chnl_data  (dma_data),
    .done                 (done),
    .debug                (debug)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard / monitor: sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 64'(dma_valid), 64'd1);
        check("hold_data", dma_data, prev_data);
      end
      if (dma_valid && dma_ready) begin
        words_seen++;
        last_hs_cyc = cyc;
        got_q.push_back(dma_data);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h expected no word", dma_data);
        end else begin
          check("word", dma_data, exp_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_valid = dma_valid;
      prev_ready = dma_ready;
      prev_data  = dma_data;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Reference model: word w holds predictions 8w..8w+7, lane 0 in the LSBs
  task automatic model_burst(input int len);
    for (int w = 0; w * 8 < len; w++) begin
      logic [63:0] word;
      word = 64'd0;
      for (int l = 0; l < 8; l++)
        if (w * 8 + l < len) word[8*l +: 8] = pred_q[w*8 + l];
      exp_q.push_back(word);
    end
  endtask

  task automatic fill_preds(input int len, input logic [7:0] base, input bit rnd);
    pred_q.delete();
    for (int k = 0; k < len; k++)
      pred_q.push_back(rnd ? 8'($urandom) : 8'(base + 8'(k)));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    start = 1'b0;
    pred_valid = 1'b0;
    dma_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pred_ready", 64'(pred_ready), 64'd0);
    check("rst_dma_valid", 64'(dma_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_debug", 64'(debug), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // Driver: start a burst, feed pred_q with throttling, wait for done
  task automatic run_burst(input int len, input int vpct, input int rpct,
                           input int stall, input int abort);
    int idx;
    int n;
    int d0;
    int w0;
    idx = 0;
    n = 0;
    model_burst(len);
    d0 = done_cnt;
    w0 = words_seen;
    got_q.delete();
    @(posedge clk); #1;
    start = 1'b1;
    burst_len = 32'(len);
    @(posedge clk); #1;
    start = 1'b0;
    burst_len = $urandom;
    @(negedge clk);
    check("ready_after_start", 64'(pred_ready), 64'(len > 0));
    while (n < 20000) begin
      if (abort > 0 && idx >= abort) break;
      if (done_cnt > d0 && idx >= len) break;
      @(posedge clk); #1;
      pred_valid = (idx < len) && ($urandom_range(99) < vpct);
      if (idx < len) pred_data = pred_q[idx];
      else           pred_data = 8'h00;
      dma_ready = (n < stall) ? 1'b0 : ($urandom_range(99) < rpct);
      @(negedge clk);
      if (pred_valid && pred_ready) idx++;
      if (stall > 0 && n == stall - 1) begin
        check("accepted_when_full", 64'(idx), 64'(8 * DEPTH));
        check("ready_low_when_full", 64'(pred_ready), 64'd0);
        check("valid_when_full", 64'(dma_valid), 64'd1);
      end
      n++;
    end
    pred_valid = 1'b0;
    if (n >= 20000) begin
      tests++;
      fails++;
      $display("FAIL burst_timeout: got %0d accepted expected %0d", idx, len);
    end
    if (abort > 0) begin
      check("words_before_abort", 64'(words_seen - w0), 64'(abort / 8));
    end else begin
      repeat (3) @(negedge clk);
      check("done_once", 64'(done_cnt - d0), 64'd1);
      check("word_count", 64'(words_seen - w0), 64'((len + 7) / 8));
      if (len > 0) check("done_latency", 64'(done_cyc - last_hs_cyc), 64'd2);
    end
  endtask

  initial begin
    vecs[0] = '{8,  8'h01, 1, 64'h0807060504030201, 64'h0807060504030201};
    vecs[1] = '{11, 8'h10, 2, 64'h1716151413121110, 64'h00000000001A1918};
    vecs[2] = '{0,  8'h00, 0, 64'h0, 64'h0};
    vecs[3] = '{1,  8'hAA, 1, 64'h00000000000000AA, 64'h00000000000000AA};
    vecs[4] = '{9,  8'h40, 2, 64'h4746454443424140, 64'h0000000000000048};

    do_reset();

    // Directed table
    for (int i = 0; i < 5; i++) begin
      fill_preds(vecs[i].len, vecs[i].base, 1'b0);
      run_burst(vecs[i].len, 100, 100, 0, 0);
      check("table_words", 64'(got_q.size()), 64'(vecs[i].nwords));
      if (vecs[i].nwords > 0) begin
        check("table_first", got_q[0], vecs[i].first);
        check("table_last", got_q[got_q.size() - 1], vecs[i].last);
      end
    end

    // Back-pressure: sink stalled 40 cycles, FIFO fills to DEPTH words
    fill_preds(64, 8'h80, 1'b0);
    run_burst(64, 100, 100, 40, 0);
    check("stall_words", 64'(got_q.size()), 64'd8);

    // Reset after 20 of 40 predictions, then a fresh burst
    fill_preds(40, 8'h30, 1'b0);
    run_burst(40, 100, 100, 0, 20);
    check("pending_discarded", 64'(exp_q.size()), 64'd3);
    do_reset();
    fill_preds(8, 8'hC0, 1'b0);
    run_burst(8, 100, 100, 0, 0);
    check("after_reset_word", got_q[0], 64'hC7C6C5C4C3C2C1C0);

    // Long randomly throttled burst
    fill_preds(1000, 8'h00, 1'b1);
    run_burst(1000, 70, 60, 0, 0);
`ifdef PRED_PACK_DEBUG_EN
    check("debug_words_out", 64'(debug[31:16]), 64'd125);
    check("debug_state_idle", 64'(debug[1:0]), 64'd0);
`else
    check("debug_tied_zero", 64'(debug), 64'd0);
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
